// File: rtl/noc_pkg.sv
// Shared flit types for the NoC merge/decode stages.
// A tagged flit carries its data plus the 1-bit input it arrived on.
package noc_pkg;
  localparam int FLIT_W   = 9;
  localparam int ADDR_MSB = 8;
  localparam int ADDR_LSB = 5;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic              src_t;

  typedef struct packed {
    src_t  src;
    flit_t data;
  } tagged_flit_t;
endpackage

// File: rtl/noc_flit_fifo.sv
// Small FIFO of tagged flits; the head entry is read straight from registered storage.
import noc_pkg::*;

module noc_flit_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  tagged_flit_t             wdata,
  input  logic                     pop,
  output tagged_flit_t             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  tagged_flit_t    mem [DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [PW:0]     cnt;
  logic            push_ok, pop_ok;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr];
  assign count   = cnt;

  // Storage is cleared too so the head reads as zero straight out of reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (pop_ok) rptr <= rptr + 1'b1;
      if (push_ok && !pop_ok)      cnt <= cnt + 1'b1;
      else if (!push_ok && pop_ok) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/noc_merge2_rr.sv
// Two-input round-robin flit merge: arbitrates, tags with source, buffers in a FIFO.
import noc_pkg::*;

module noc_merge2_rr #(
  parameter int W     = 9,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [W-1:0]            in0_data,
  input  logic                    in0_valid,
  output logic                    in0_ready,
  input  logic [W-1:0]            in1_data,
  input  logic                    in1_valid,
  output logic                    in1_ready,
  output logic [W-1:0]            out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_src,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [CNT_W-1:0]        grant_cnt0,
  output logic [CNT_W-1:0]        grant_cnt1
);
  logic         ptr;
  logic         full, empty, accept;
  logic         xfer0, xfer1;
  tagged_flit_t wdata, rdata;

  // Accept ignores out_ready on purpose: a full FIFO never takes a flit, even with a pop.
  assign accept = !full && !RESET;

  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    if (in0_valid && in1_valid) begin
      if (ptr) in1_ready = accept;
      else     in0_ready = accept;
    end else begin
      in0_ready = in0_valid && accept;
      in1_ready = in1_valid && accept;
    end
  end

  assign xfer0      = in0_valid && in0_ready;
  assign xfer1      = in1_valid && in1_ready;
  assign wdata.src  = xfer1;
  assign wdata.data = xfer1 ? in1_data : in0_data;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ptr        <= 1'b0;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (xfer0) begin
        ptr        <= 1'b1;
        grant_cnt0 <= grant_cnt0 + 1'b1;
      end else if (xfer1) begin
        ptr        <= 1'b0;
        grant_cnt1 <= grant_cnt1 + 1'b1;
      end
    end
  end

  noc_flit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (xfer0 || xfer1),
    .wdata (wdata),
    .pop   (out_ready),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  assign out_valid = !empty;
  assign out_data  = rdata.data;
  assign out_src   = rdata.src;
endmodule

// File: tb/tb_noc_merge2_rr.sv
// Bench for noc_merge2_rr: reference model + scoreboard on every cycle, plus scenario tasks.
module tb_noc_merge2_rr;
  localparam int W = 9, DEPTH = 2, CNT_W = 4;

  logic CLK, RESET;
  logic [W-1:0] in0_data, in1_data, out_data;
  logic in0_valid, in0_ready, in1_valid, in1_ready, out_valid, out_ready, out_src;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

  int checks = 0;
  int failures = 0;

  noc_merge2_rr #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
    .occupancy(occupancy), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  // Reference model: expected FIFO contents as {src,data}, priority pointer, counters.
  logic [W:0]       m_q[$];
  logic             m_ptr;
  logic [CNT_W-1:0] m_c0, m_c1;
  logic             e_acc, e_r0, e_r1;

  always @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      m_q.delete();
      m_ptr = 0; m_c0 = 0; m_c1 = 0;
    end else begin
      e_acc = (m_q.size() < DEPTH);
      e_r0 = 0; e_r1 = 0;
      if (in0_valid && in1_valid) begin
        if (m_ptr) e_r1 = e_acc; else e_r0 = e_acc;
      end else begin
        e_r0 = in0_valid && e_acc;
        e_r1 = in1_valid && e_acc;
      end
      checks++;
      if ({in0_ready, in1_ready} !== {e_r0, e_r1}) begin
        failures++;
        $display("FAIL sb_ready got=%b%b exp=%b%b t=%0t", in0_ready, in1_ready, e_r0, e_r1, $time);
      end
      checks++;
      if (occupancy !== ($clog2(DEPTH)+1)'(m_q.size()) || out_valid !== (m_q.size() > 0)) begin
        failures++;
        $display("FAIL sb_occ got occ=%0d vld=%b exp occ=%0d t=%0t", occupancy, out_valid, m_q.size(), $time);
      end
      checks++;
      if (grant_cnt0 !== m_c0 || grant_cnt1 !== m_c1) begin
        failures++;
        $display("FAIL sb_cnt got=%0d/%0d exp=%0d/%0d t=%0t", grant_cnt0, grant_cnt1, m_c0, m_c1, $time);
      end
      if (m_q.size() > 0) begin
        checks++;
        if ({out_src, out_data} !== m_q[0]) begin
          failures++;
          $display("FAIL sb_head got=%h exp=%h t=%0t", {out_src, out_data}, m_q[0], $time);
        end
        if (out_ready) void'(m_q.pop_front());
      end
      if (e_r0 && in0_valid) begin
        m_q.push_back({1'b0, in0_data}); m_ptr = 1; m_c0 = m_c0 + 1'b1;
      end else if (e_r1 && in1_valid) begin
        m_q.push_back({1'b1, in1_data}); m_ptr = 0; m_c1 = m_c1 + 1'b1;
      end
    end
  end

  task automatic step;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset;
    in0_valid = 0; in1_valid = 0; out_ready = 0;
    in0_data = '0; in1_data = '0;
    RESET = 1;
    step; step;
    RESET = 0;
  endtask

  task automatic test_reset;
    in0_valid = 1; in1_valid = 0; out_ready = 0; in0_data = 9'h111; in1_data = '0;
    RESET = 1;
    #3;
    checks++;
    if (out_valid !== 0 || occupancy !== 0 || out_data !== 0 || out_src !== 0 ||
        in0_ready !== 0 || in1_ready !== 0 || grant_cnt0 !== 0 || grant_cnt1 !== 0) begin
      failures++;
      $display("FAIL reset_por got vld=%b occ=%0d d=%h s=%b rdy=%b%b cnt=%0d/%0d exp all zero",
               out_valid, occupancy, out_data, out_src, in0_ready, in1_ready, grant_cnt0, grant_cnt1);
    end
    step; step;
    RESET = 0;
    step;
    in0_data = 9'h112;
    step;
    checks++;
    if (occupancy !== 2) begin
      failures++;
      $display("FAIL reset_prefill got occ=%0d exp 2", occupancy);
    end
    RESET = 1;
    #1;
    checks++;
    if (out_valid !== 0 || occupancy !== 0 || in0_ready !== 0) begin
      failures++;
      $display("FAIL reset_mid got vld=%b occ=%0d rdy0=%b exp 0/0/0", out_valid, occupancy, in0_ready);
    end
    step;
    RESET = 0;
    in0_valid = 1; in1_valid = 1; in0_data = 9'h120; in1_data = 9'h0E0;
    #1;
    checks++;
    if (grant_cnt0 !== 0 || grant_cnt1 !== 0 || in0_ready !== 1 || in1_ready !== 0) begin
      failures++;
      $display("FAIL reset_after got cnt=%0d/%0d rdy=%b%b exp 0/0 10", grant_cnt0, grant_cnt1, in0_ready, in1_ready);
    end
    step;
    in0_valid = 0; in1_valid = 0;
  endtask

  task automatic test_single;
    do_reset;
    out_ready = 1; in0_valid = 1; in0_data = 9'h1A5;
    #1;
    checks++;
    if (in0_ready !== 1) begin failures++; $display("FAIL single_rdy got=%b exp 1", in0_ready); end
    step;
    checks++;
    if (out_valid !== 1 || out_data !== 9'h1A5 || out_src !== 0) begin
      failures++;
      $display("FAIL single_first got vld=%b d=%h s=%b exp 1/1a5/0", out_valid, out_data, out_src);
    end
    in0_data = 9'h0F3;
    step;
    checks++;
    if (out_data !== 9'h0F3 || out_src !== 0) begin
      failures++;
      $display("FAIL single_second got d=%h s=%b exp 0f3/0", out_data, out_src);
    end
    in0_valid = 0;
    step;
    checks++;
    if (grant_cnt0 !== 2 || out_valid !== 0) begin
      failures++;
      $display("FAIL single_cnt got cnt0=%0d vld=%b exp 2/0", grant_cnt0, out_valid);
    end
  endtask

  task automatic test_contention;
    int i0, i1;
    logic [W-1:0] exp_d;
    do_reset;
    i0 = 0; i1 = 0;
    out_ready = 1; in0_valid = 1; in1_valid = 1;
    for (int k = 0; k < 8; k++) begin
      in0_data = W'(9'h100 + i0);
      in1_data = W'(9'h0E0 + i1);
      #1;
      checks++;
      if (in0_ready !== (k % 2 == 0) || in1_ready !== (k % 2 == 1)) begin
        failures++;
        $display("FAIL contend_grant k=%0d got rdy=%b%b exp in%0d", k, in0_ready, in1_ready, k % 2);
      end
      exp_d = (k % 2 == 0) ? in0_data : in1_data;
      step;
      checks++;
      if (out_src !== 1'(k % 2) || out_data !== exp_d) begin
        failures++;
        $display("FAIL contend_out k=%0d got s=%b d=%h exp s=%0d d=%h", k, out_src, out_data, k % 2, exp_d);
      end
      if (k % 2 == 0) i0++; else i1++;
    end
    in0_valid = 0; in1_valid = 0;
    step;
  endtask

  task automatic test_full;
    do_reset;
    out_ready = 0; in0_valid = 1; in1_valid = 1;
    in0_data = 9'h150; in1_data = 9'h060;
    #1;
    checks++;
    if (in0_ready !== 1 || in1_ready !== 0) begin failures++; $display("FAIL full_g0 got rdy=%b%b exp 10", in0_ready, in1_ready); end
    step;
    in0_data = 9'h151;
    #1;
    checks++;
    if (in0_ready !== 0 || in1_ready !== 1) begin failures++; $display("FAIL full_g1 got rdy=%b%b exp 01", in0_ready, in1_ready); end
    step;
    in1_data = 9'h061;
    #1;
    checks++;
    if (in0_ready !== 0 || in1_ready !== 0 || occupancy !== 2) begin
      failures++;
      $display("FAIL full_stall got rdy=%b%b occ=%0d exp 00/2", in0_ready, in1_ready, occupancy);
    end
    step;
    out_ready = 1;
    #1;
    checks++;
    if (in0_ready !== 0 || in1_ready !== 0 || out_data !== 9'h150 || out_src !== 0) begin
      failures++;
      $display("FAIL full_popgate got rdy=%b%b d=%h s=%b exp 00/150/0", in0_ready, in1_ready, out_data, out_src);
    end
    step;
    checks++;
    if (in0_ready !== 1 || occupancy !== 1 || out_data !== 9'h060 || out_src !== 1) begin
      failures++;
      $display("FAIL full_resume got rdy0=%b occ=%0d d=%h s=%b exp 1/1/060/1", in0_ready, occupancy, out_data, out_src);
    end
    step;
    in0_valid = 0; in1_valid = 0;
    step; step; step;
  endtask

  task automatic test_push_pop;
    do_reset;
    out_ready = 0; in1_valid = 1; in1_data = 9'h0A0;
    step;
    out_ready = 1;
    #1;
    checks++;
    if (occupancy !== 1) begin failures++; $display("FAIL pp_fill got occ=%0d exp 1", occupancy); end
    for (int k = 1; k <= 5; k++) begin
      in1_data = W'(9'h0A0 + k);
      step;
      checks++;
      if (occupancy !== 1 || out_data !== W'(9'h0A0 + k) || out_src !== 1) begin
        failures++;
        $display("FAIL pp_adv k=%0d got occ=%0d d=%h s=%b exp 1/%h/1", k, occupancy, out_data, out_src, W'(9'h0A0 + k));
      end
    end
    in1_valid = 0;
    step;
    checks++;
    if (out_valid !== 0) begin failures++; $display("FAIL pp_drain got vld=%b exp 0", out_valid); end
  endtask

  task automatic test_cnt_wrap;
    do_reset;
    out_ready = 1; in1_valid = 1;
    for (int k = 0; k < 17; k++) begin
      in1_data = W'(k * 7);
      step;
    end
    in1_valid = 0;
    step;
    checks++;
    if (grant_cnt1 !== 4'd1 || grant_cnt0 !== 4'd0) begin
      failures++;
      $display("FAIL cnt_wrap got cnt1=%0d cnt0=%0d exp 1/0", grant_cnt1, grant_cnt0);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_full;
    test_push_pop;
    test_cnt_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
